time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The module SHALL have parameter MAX_HOUR, default 23, which sets the highest hour value before the hour counter wraps to 00.
REQ-002 The module SHALL have port clk, input, 1 bit: system clock, the same clock that drives clock_divider.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port clk1hz, input, 1 bit: the square wave from clock_divider; each rising edge marks one second.
REQ-005 The module SHALL have port mode_btn, input, 1 bit: single-cycle pulse, debounced upstream; advances the mode.
REQ-006 The module SHALL have port inc_btn, input, 1 bit: single-cycle pulse, debounced upstream; increments the selected field.
REQ-007 The module SHALL have outputs hr_t[1:0], hr_o[3:0], min_t[2:0], min_o[3:0], sec_t[2:0] and sec_o[3:0], all registered, carrying the time as BCD tens and ones digits.
REQ-008 The module SHALL have output mode[1:0], registered: 0 = RUN, 1 = SET_HR, 2 = SET_MIN.
REQ-009 The module SHALL have output day_tick, 1 bit, registered: a one-cycle pulse when the time wraps from 23:59:59 to 00:00:00.

Function
REQ-010 clk1hz SHALL pass through two flops, s1 then s2, and the internal tick SHALL equal s1 AND NOT s2.
REQ-011 The time outputs SHALL change on the 2nd rising clk edge after clk1hz goes high.
REQ-012 Exactly one tick SHALL occur per clk1hz rising edge; a level held high SHALL NOT retrigger.
REQ-013 In RUN, a tick SHALL increment the seconds, with these carries:
  - seconds 59 wraps to 00 and carries into minutes;
  - minutes 59 wraps to 00 and carries into hours;
  - hours MAX_HOUR wraps to 00.
REQ-014 Every digit SHALL stay within legal BCD at all times: ones 0-9, sec_t/min_t 0-5, hr_t 0-2.
REQ-015 day_tick SHALL assert in the same cycle the outputs show 00:00:00 after a wrap, in RUN only.
REQ-016 The mode FSM SHALL move RUN -> SET_HR -> SET_MIN -> RUN, one step per mode_btn pulse.
REQ-017 The RUN -> SET_HR transition SHALL clear the seconds to 00 and discard any tick in that cycle.
REQ-018 In SET_HR and SET_MIN, ticks SHALL be ignored and the time SHALL be frozen.
REQ-019 inc_btn in SET_HR SHALL increment the hours, wrapping MAX_HOUR -> 00 with no effect on minutes.
REQ-020 inc_btn in SET_MIN SHALL increment the minutes, wrapping 59 -> 00 with no carry into hours.
REQ-021 inc_btn SHALL be ignored in RUN.
REQ-022 If mode_btn and inc_btn arrive in the same cycle, mode_btn SHALL win and inc_btn SHALL be dropped.
REQ-023 On the SET_MIN -> RUN transition, the seconds SHALL stay at 00 and counting SHALL resume from the next tick.
REQ-024 A tick in the same cycle as a RUN -> SET_HR mode_btn SHALL NOT modify the time beyond the seconds clear of REQ-017.

Reset
REQ-025 When rst is high at a clk edge, the module SHALL set mode = RUN, all digits = 0 (00:00:00) and day_tick = 0.
REQ-026 Reset SHALL force s1 = 1 and s2 = 1, so a clk1hz that is already high at reset release produces no tick.
REQ-027 Reset SHALL take priority over every other input in the same cycle, including in mid-setting.
REQ-028 After reset deasserts, the first tick SHALL come only from a genuine 0 -> 1 transition of clk1hz.

Structure
REQ-029 The shared header time_defs.vh SHALL hold the mode encodings (MODE_RUN, MODE_SET_HR, MODE_SET_MIN) and the constants MAX_SEC = 59 and MAX_MIN = 59.
REQ-030 A sub-module bcd_mod_counter SHALL implement one two-digit BCD counter with:
  - parameter for the maximum tens and ones values;
  - inputs clr and inc;
  - outputs tens, ones and a combinational carry (asserted when inc is applied at the maximum value).
REQ-031 time_keeper SHALL instantiate bcd_mod_counter three times (seconds, minutes, hours) and contain the edge detector and the mode FSM.
REQ-032 The module SHALL use no clock derived from clk1hz; all flops SHALL be clocked by clk.

Verification
REQ-033 Hold rst 2 cycles with clk1hz = 1, then release -> no tick; outputs stay at 00:00:00 and mode = 0.
REQ-034 From 00:00:58, apply 2 clk1hz rising edges -> the outputs read 00:00:59, then 00:01:00, each appearing exactly 2 clk edges after its clk1hz edge.
REQ-035 Preload 23:59:59 via set mode, then return to RUN and apply 1 tick -> 00:00:00 with day_tick high for exactly 1 cycle.
REQ-036 In SET_HR at hour 23, pulse inc_btn -> hour 00 and minutes unchanged; in SET_MIN at minute 59, pulse inc_btn -> minute 00 and hour unchanged.
REQ-037 In SET_MIN, drive mode_btn and inc_btn in the same cycle -> mode = RUN and minutes unchanged; drive a tick during SET_HR -> the time is unchanged.
REQ-038 Pulse mode_btn at 12:34:56 in the same cycle as a tick -> mode = SET_HR and the outputs read 12:34:00.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared mode encodings and field limits for the time keeper.
package time_keeper_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam int MAX_SEC = 59;
  localparam int MAX_MIN = 59;

  // Split a decimal limit into its BCD tens and ones digits.
  function automatic int tens_of(int v);
    return v / 10;
  endfunction

  function automatic int ones_of(int v);
    return v % 10;
  endfunction

endpackage

// File: rtl/time_keeper_bcd_mod_counter.sv
// Two-digit BCD modulo counter. It wraps from MAX_T:MAX_O to 00, and
// carry flags that wrap combinationally so the next field can chain on it.
module bcd_mod_counter #(
  parameter int TW    = 3,
  parameter int MAX_T = 5,
  parameter int MAX_O = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [TW-1:0] tens,
  output logic [3:0]    ones,
  output logic          carry
);

  logic [TW-1:0] r_tens;
  logic [3:0]    r_ones;
  logic          w_at_max;

  assign w_at_max = (r_tens == TW'(MAX_T)) && (r_ones == 4'(MAX_O));
  assign carry    = inc & w_at_max;
  assign tens     = r_tens;
  assign ones     = r_ones;

  // Digit update: reset and clear win over increment; ones roll into tens at 9.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (inc) begin
      if (w_at_max) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_ones == 4'd9) begin
        r_tens <= r_tens + TW'(1);
        r_ones <= '0;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds clock, advanced by the rising edges of clk1hz.
// Those edges are detected in the clk domain. A three-state mode FSM
// lets the user set the hours and the minutes.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [1:0] hr_t,
  output logic [3:0] hr_o,
  output logic [2:0] min_t,
  output logic [3:0] min_o,
  output logic [2:0] sec_t,
  output logic [3:0] sec_o,
  output logic [1:0] mode,
  output logic       day_tick
);

  logic  r_s1, r_s2;
  mode_e r_mode;
  logic  r_day_tick;

  logic w_tick;
  logic w_run, w_set_hr, w_set_min;
  logic w_sec_clr, w_sec_inc, w_min_inc, w_hr_inc;
  logic w_sec_carry, w_min_carry, w_hr_carry;

  // Synchroniser and edge detector. Reset loads 1s, so a clk1hz that is
  // already high when reset is released is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= clk1hz;
      r_s2 <= r_s1;
    end
  end

  assign w_tick    = r_s1 & ~r_s2;
  assign w_run     = (r_mode == MODE_RUN);
  assign w_set_hr  = (r_mode == MODE_SET_HR);
  assign w_set_min = (r_mode == MODE_SET_MIN);

  // mode_btn takes priority. In RUN it clears the seconds and drops any tick
  // in that cycle. In the set modes it drops a coincident inc_btn.
  assign w_sec_clr = w_run & mode_btn;
  assign w_sec_inc = w_run & w_tick & ~mode_btn;
  assign w_min_inc = (w_run & w_sec_carry) | (w_set_min & inc_btn & ~mode_btn);
  assign w_hr_inc  = (w_run & w_sec_carry & w_min_carry) |
                     (w_set_hr & inc_btn & ~mode_btn);

  bcd_mod_counter #(
    .TW   (3),
    .MAX_T(tens_of(MAX_SEC)),
    .MAX_O(ones_of(MAX_SEC))
  ) u_sec (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_sec_clr),
    .inc  (w_sec_inc),
    .tens (sec_t),
    .ones (sec_o),
    .carry(w_sec_carry)
  );

  bcd_mod_counter #(
    .TW   (3),
    .MAX_T(tens_of(MAX_MIN)),
    .MAX_O(ones_of(MAX_MIN))
  ) u_min (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (w_min_inc),
    .tens (min_t),
    .ones (min_o),
    .carry(w_min_carry)
  );

  bcd_mod_counter #(
    .TW   (2),
    .MAX_T(tens_of(MAX_HOUR)),
    .MAX_O(ones_of(MAX_HOUR))
  ) u_hr (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (w_hr_inc),
    .tens (hr_t),
    .ones (hr_o),
    .carry(w_hr_carry)
  );

  // Mode FSM and the day_tick pulse. A full hour wrap in RUN happens only
  // through the carry chain, so that wrap sets day_tick in the same cycle
  // that the counters load 00:00:00.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= MODE_RUN;
      r_day_tick <= 1'b0;
    end else begin
      r_day_tick <= w_run & w_hr_carry;
      if (mode_btn) begin
        case (r_mode)
          MODE_RUN:    r_mode <= MODE_SET_HR;
          MODE_SET_HR: r_mode <= MODE_SET_MIN;
          default:     r_mode <= MODE_RUN;
        endcase
      end
    end
  end

  assign mode     = r_mode;
  assign day_tick = r_day_tick;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper. Stimulus pushes each expected output
// change, with the clk cycle on which it should appear. A monitor pops and
// compares an entry on every observed change of the outputs, so a missing
// change, an extra change or a late change is each reported.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst, clk1hz, mode_btn, inc_btn;
  logic [1:0] hr_t;
  logic [3:0] hr_o;
  logic [2:0] min_t;
  logic [3:0] min_o;
  logic [2:0] sec_t;
  logic [3:0] sec_o;
  logic [1:0] mode;
  logic       day_tick;

  typedef struct {
    logic [22:0] v;
    int          cyc;   // -1: any cycle
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  time_keeper #(.MAX_HOUR(23)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk1hz  (clk1hz),
    .mode_btn(mode_btn),
    .inc_btn (inc_btn),
    .hr_t    (hr_t),
    .hr_o    (hr_o),
    .min_t   (min_t),
    .min_o   (min_o),
    .sec_t   (sec_t),
    .sec_o   (sec_o),
    .mode    (mode),
    .day_tick(day_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [22:0] enc(int h, int m, int s, int md, int dt);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), 2'(md), 1'(dt)};
  endfunction

  task automatic push(logic [22:0] v, int c);
    exp_t e;
    e.v   = v;
    e.cyc = c;
    q.push_back(e);
  endtask

  // One clk1hz period. If chg is set, an output change is expected 2 edges after the rise.
  task automatic tick(int h, int m, int s, int md, bit chg);
    @(negedge clk);
    if (chg) push(enc(h, m, s, md, 0), cyc + 2);
    clk1hz = 1'b1;
    repeat (3) @(negedge clk);
    clk1hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One-cycle pulse on the buttons and/or rst. The change is expected on the next edge.
  task automatic press(bit mb, bit ib, bit r, int h, int m, int s, int md);
    @(negedge clk);
    push(enc(h, m, s, md, 0), cyc + 1);
    mode_btn = mb;
    inc_btn  = ib;
    rst      = r;
    @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    rst      = 1'b0;
  endtask

  // Monitor: compare against the scoreboard whenever the visible outputs change.
  initial begin
    logic [22:0] cur, prev;
    bit          first;
    exp_t        e;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {hr_t, hr_o, min_t, min_o, sec_t, sec_o, mode, day_tick};
        if (first || cur != prev) begin
          n_run++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
          end else begin
            e = q.pop_front();
            if (cur !== e.v || (e.cyc >= 0 && cyc != e.cyc)) begin
              n_fail++;
              $display("FAIL output_change#%0d: got %h at cycle %0d, required %h at cycle %0d",
                       n_run, cur, cyc, e.v, e.cyc);
            end
          end
        end
        prev  = cur;
        first = 1'b0;
      end
    end
  end

  initial begin
    int c;
    rst      = 1'b1;
    clk1hz   = 1'b1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    // Hold reset for 2 cycles with clk1hz high. No tick is allowed after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(enc(0, 0, 0, 0, 0), -1);
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    clk1hz = 1'b0;
    repeat (3) @(negedge clk);

    // Count up to 00:00:58, then check 59 and the carry into the minutes.
    for (int s = 1; s <= 58; s++) tick(0, 0, s, 0, 1);
    tick(0, 0, 59, 0, 1);
    tick(0, 1, 0, 0, 1);

    // Set 12:34, then run up to 12:34:56.
    press(1, 0, 0, 0, 1, 0, 1);
    for (int h = 1; h <= 12; h++) press(0, 1, 0, h, 1, 0, 1);
    press(1, 0, 0, 12, 1, 0, 2);
    for (int m = 2; m <= 34; m++) press(0, 1, 0, 12, m, 0, 2);
    press(1, 0, 0, 12, 34, 0, 0);
    for (int s = 1; s <= 56; s++) tick(12, 34, s, 0, 1);

    // A mode_btn that coincides with a tick: the seconds clear and the tick is dropped.
    @(negedge clk);
    clk1hz = 1'b1;
    @(negedge clk);
    push(enc(12, 34, 0, 1, 0), cyc + 1);
    mode_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
    repeat (2) @(negedge clk);
    clk1hz = 1'b0;
    repeat (2) @(negedge clk);

    // A tick during SET_HR must leave the time frozen.
    tick(12, 34, 0, 1, 0);

    // Hour wrap 23 -> 00 in SET_HR leaves the minutes at 34.
    for (int h = 13; h <= 23; h++) press(0, 1, 0, h, 34, 0, 1);
    press(0, 1, 0, 0, 34, 0, 1);
    for (int h = 1; h <= 23; h++) press(0, 1, 0, h, 34, 0, 1);

    // Minute wrap 59 -> 00 in SET_MIN leaves the hour at 23.
    press(1, 0, 0, 23, 34, 0, 2);
    for (int m = 35; m <= 59; m++) press(0, 1, 0, 23, m, 0, 2);
    press(0, 1, 0, 23, 0, 0, 2);
    for (int m = 1; m <= 59; m++) press(0, 1, 0, 23, m, 0, 2);

    // mode_btn and inc_btn together: mode_btn wins and the minutes stay at 59.
    press(1, 1, 0, 23, 59, 0, 0);

    // Run to 23:59:59, then wrap to midnight with a single-cycle day_tick.
    for (int s = 1; s <= 59; s++) tick(23, 59, s, 0, 1);
    @(negedge clk);
    c = cyc;
    push(enc(0, 0, 0, 0, 1), c + 2);
    push(enc(0, 0, 0, 0, 0), c + 3);
    clk1hz = 1'b1;
    repeat (3) @(negedge clk);
    clk1hz = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of setting overrides the coincident buttons.
    press(1, 0, 0, 0, 0, 0, 1);
    press(0, 1, 0, 1, 0, 0, 1);
    press(1, 1, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // After reset, a genuine 0 -> 1 edge on clk1hz counts again.
    tick(0, 0, 1, 0, 1);
    repeat (8) @(negedge clk);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL missing_change: got no change, required %h at cycle %0d", e.v, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
